fft_frame_unpacker: RTL and testbench

Output-side reader for the dual 8-point FFT stream. It drains the 32-word result frames that the FFT top writes into its output FIFO and reassembles each frame into two parallel 8-point complex vectors. Each completed frame is presented to the downstream consumer through a single valid/ready handshake. The block sits between the output FIFO's read port and any parallel-result consumer, such as a magnitude or compare stage.

---
 rtl/fft_frame_unpacker.sv | 74 +++++++
 tb/tb_fft_frame_unpacker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fft_frame_unpacker.sv
// fft_frame_unpacker: drains 32-word FFT result frames from the output FIFO and
// presents them as four 8-point vectors behind one valid/ready handshake.
module fft_frame_unpacker #(
   parameter int DATA_WIDTH      = 16,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              fifo_empty,
   output logic                              fifo_rd_en,
   input  logic signed [DATA_WIDTH-1:0]      fifo_rd_data,
   output logic signed [DATA_WIDTH-1:0]      res_real_1 [0:7],
   output logic signed [DATA_WIDTH-1:0]      res_imag_1 [0:7],
   output logic signed [DATA_WIDTH-1:0]      res_real_2 [0:7],
   output logic signed [DATA_WIDTH-1:0]      res_imag_2 [0:7],
   output logic                              frame_valid,
   input  logic                              frame_ready,
   output logic [FRAME_CNT_WIDTH-1:0]        frame_count
);
   typedef enum logic {FILL, HOLD} state_t;
   state_t                        state_q, state_d;
   logic [5:0]                    issue_q, issue_d, cap_q, cap_d;
   logic                          pend_q, pend_d;
   logic [FRAME_CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic signed [DATA_WIDTH-1:0]  word_q [0:31];
   logic signed [DATA_WIDTH-1:0]  word_d [0:31];
   always_comb begin
      state_d     = state_q;
      issue_d     = issue_q;
      cap_d       = cap_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      frame_valid = state_q == HOLD;
      // gated by rst so no strobe escapes while the block is held in reset
      fifo_rd_en  = rst && state_q == FILL && issue_q < 6'd32 && !fifo_empty;
      pend_d      = fifo_rd_en;
      issue_d     = fifo_rd_en ? issue_q + 6'd1 : issue_q;
      if (pend_q) begin
         word_d[cap_q[4:0]] = fifo_rd_data;
         cap_d              = cap_q + 6'd1;
         state_d            = cap_q == 6'd31 ? HOLD : state_q;
      end
      if (frame_valid && frame_ready) begin
         state_d = FILL;
         issue_d = '0;
         cap_d   = '0;
         cnt_d   = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         issue_q <= '0;
         cap_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         word_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         issue_q <= issue_d;
         cap_q   <= cap_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end
   for (genvar i = 0; i < 8; i++) begin : g_map
      assign res_real_1[i] = word_q[i];
      assign res_imag_1[i] = word_q[8 + i];
      assign res_real_2[i] = word_q[16 + i];
      assign res_imag_2[i] = word_q[24 + i];
   end
   assign frame_count = cnt_q;
endmodule

// File: tb/tb_fft_frame_unpacker.sv
// tb_fft_frame_unpacker: random and directed frames through a queue-based FIFO model,
// checked against the expected word-to-bin mapping of each frame.
module tb_fft_frame_unpacker;
   localparam int DW = 16;
   localparam int CW = 2;
   logic clk = 1'b0, rst = 1'b0, fifo_empty = 1'b1, frame_ready = 1'b0;
   logic fifo_rd_en, frame_valid;
   logic signed [DW-1:0] fifo_rd_data = '0;
   logic signed [DW-1:0] rr1 [0:7];
   logic signed [DW-1:0] ri1 [0:7];
   logic signed [DW-1:0] rr2 [0:7];
   logic signed [DW-1:0] ri2 [0:7];
   logic [CW-1:0] frame_count;
   int passed = 0, total = 0, cnt = 0, gap = 0, pidx = 0;
   logic [31:0] gmask = '0;
   logic signed [DW-1:0] fq [$];
   logic signed [DW-1:0] eq [$];
   logic signed [DW-1:0] w [0:31];
   bit eff;
   always #5 clk = ~clk;
   fft_frame_unpacker #(.DATA_WIDTH(DW), .FRAME_CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .res_real_1(rr1), .res_imag_1(ri1),
      .res_real_2(rr2), .res_imag_2(ri2), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .frame_count(frame_count)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   function automatic void upd();
      fifo_empty = (gap > 0) || (fq.size() == 0);
   endfunction
   // one clock of the FIFO model: a read granted at a posedge returns data at the next negedge
   task automatic step();
      eff = fifo_rd_en && !fifo_empty;
      @(posedge clk);
      @(negedge clk);
      if (gap > 0) gap--;
      if (eff) begin
         fifo_rd_data = fq.pop_front();
         if (gmask[pidx % 32]) gap = 3;
         pidx++;
      end
      upd();
      #1;
   endtask
   task automatic push_frame(input bit ramp);
      for (int i = 0; i < 32; i++) begin
         fq.push_back(ramp ? DW'(i - 16) : DW'($urandom));
         eq.push_back(fq[fq.size() - 1]);
      end
      upd();
      #1;
   endtask
   task automatic chk_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s rr1[%0d]", tag, i), rr1[i], 0);
         chk($sformatf("%s ri1[%0d]", tag, i), ri1[i], 0);
         chk($sformatf("%s rr2[%0d]", tag, i), rr2[i], 0);
         chk($sformatf("%s ri2[%0d]", tag, i), ri2[i], 0);
      end
   endtask
   task automatic collect(input bit timing);
      int reads, first, last, viol, vcyc;
      reads = 0; first = -1; last = -1; viol = 0; vcyc = -1;
      for (int k = 0; k < 2000; k++) begin
         if (frame_valid) begin
            vcyc = k;
            break;
         end
         if (fifo_rd_en && fifo_empty) viol++;
         if (fifo_rd_en && !fifo_empty) begin
            reads++;
            if (first < 0) first = k;
            last = k;
         end
         step();
      end
      chk("frame_valid reached", vcyc >= 0, 1);
      chk("reads per frame", reads, 32);
      chk("read while empty", viol, 0);
      chk("rd_en with valid", fifo_rd_en, 0);
      if (timing) begin
         chk("first read cycle", first, 0);
         chk("read burst length", last - first + 1, 32);
         chk("valid latency", vcyc - first, 33);
      end
      for (int i = 0; i < 32; i++) w[i] = eq.pop_front();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("res_real_1[%0d]", i), rr1[i], w[i]);
         chk($sformatf("res_imag_1[%0d]", i), ri1[i], w[8 + i]);
         chk($sformatf("res_real_2[%0d]", i), rr2[i], w[16 + i]);
         chk($sformatf("res_imag_2[%0d]", i), ri2[i], w[24 + i]);
      end
   endtask
   task automatic accept(input int hold);
      int rdh, bad;
      rdh = 0; bad = 0;
      for (int c = 0; c < hold; c++) begin
         step();
         if (fifo_rd_en) rdh++;
         if (!frame_valid) bad++;
         for (int i = 0; i < 8; i++)
            if (rr1[i] !== w[i] || ri1[i] !== w[8 + i] || rr2[i] !== w[16 + i] || ri2[i] !== w[24 + i]) bad++;
      end
      chk("no read in hold", rdh, 0);
      chk("hold stable", bad, 0);
      frame_ready = 1'b1;
      #1;
      step();
      frame_ready = 1'b0;
      cnt++;
      chk("valid drops after accept", frame_valid, 0);
      chk("frame_count", frame_count, cnt % 4);
      if (fq.size() > 0 && gap == 0) chk("read right after accept", fifo_rd_en, 1);
   endtask
   initial begin
      #1;
      chk("reset frame_valid", frame_valid, 0);
      chk("reset rd_en", fifo_rd_en, 0);
      chk("reset frame_count", frame_count, 0);
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      #1;
      push_frame(0);
      push_frame(0);
      for (int k = 0; k < 200 && pidx < 11; k++) step();
      chk("reads before mid reset", pidx, 11);
      rst = 1'b0;
      #1;
      chk("mid reset frame_valid", frame_valid, 0);
      chk("mid reset rd_en", fifo_rd_en, 0);
      chk("mid reset frame_count", frame_count, 0);
      chk_zero("mid reset");
      step();
      step();
      fq.delete();
      eq.delete();
      pidx = 0;
      gap = 0;
      fifo_rd_data = 16'sh7777;
      upd();
      rst = 1'b1;
      #1;
      frame_ready = 1'b1;
      push_frame(1);
      collect(1);
      chk("map rr1[0]", rr1[0], -16);
      chk("map ri1[0]", ri1[0], -8);
      chk("map rr2[7]", rr2[7], 7);
      chk("map ri2[7]", ri2[7], 15);
      accept(0);
      gmask = (32'd1 << 5) | (32'd1 << 17) | (32'd1 << 30);
      frame_ready = 1'b1;
      push_frame(1);
      collect(0);
      accept(0);
      gmask = '0;
      frame_ready = 1'b0;
      push_frame(0);
      push_frame(0);
      collect(1);
      accept(20);
      collect(1);
      accept(0);
      repeat (5) begin
         gmask = $urandom & $urandom & $urandom;
         frame_ready = 1'($urandom_range(0, 1));
         push_frame(0);
         collect(0);
         accept(frame_ready ? 0 : int'($urandom_range(1, 5)));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
